// File: rtl/battleship_input_cond.sv
// battleship_input_cond
//   Conditions the raw board buttons and coordinate switches for the game FSM.
//   Every raw bit gets a two-flop synchronizer and an independent debounce
//   counter. Buttons come out as one-cycle press pulses. Switches come out as
//   stable debounced levels.
//
//   Ports
//     clk        game clock
//     rst        synchronous reset, active-high
//     start_raw  raw start button (async)
//     pA_raw     raw player-A button (async)
//     pB_raw     raw player-B button (async)
//     X_raw[1:0] raw column switches (async)
//     Y_raw[1:0] raw row switches (async)
//     start      one-cycle pulse per debounced start press
//     pAb        one-cycle pulse per debounced A press
//     pBb        one-cycle pulse per debounced B press
//     X[1:0]     debounced column
//     Y[1:0]     debounced row

// One conditioning lane: synchronizer, debounce counter, optional press pulse.
//   clk, rst  clock and synchronous active-high reset
//   raw       asynchronous raw input bit
//   out       pulse on a 0->1 debounced flip (EDGE=1) or debounced level (EDGE=0)
module bic_chan #(
  parameter int N    = 4,     // consecutive mismatch cycles before db flips
  parameter bit INV  = 1'b0,  // invert after the synchronizer (active-low input)
  parameter bit EDGE = 1'b0   // 1: output press pulse, 0: output level
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out
);
  localparam logic [7:0] LAST = 8'(N - 1);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       db_q, db_d;
  logic       pulse_q, pulse_d;
  logic [7:0] cnt_q, cnt_d;
  logic       samp;

  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    // Inversion sits after the synchronizer so db always means "pressed".
    samp = s2_q ^ INV;
    db_d  = db_q;
    cnt_d = cnt_q;
    if (samp == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      db_d  = samp;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    // Registered on the same edge db flips 0->1; release gives nothing.
    pulse_d = EDGE & db_d & ~db_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign out = EDGE ? pulse_q : db_q;
endmodule

module battleship_input_cond #(
  parameter int BTN_DEBOUNCE   = 4,
  parameter int SW_DEBOUNCE    = 4,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_raw,
  input  logic       pA_raw,
  input  logic       pB_raw,
  input  logic [1:0] X_raw,
  input  logic [1:0] Y_raw,
  output logic       start,
  output logic       pAb,
  output logic       pBb,
  output logic [1:0] X,
  output logic [1:0] Y
);
  localparam int NUM_BTN = 3;
  localparam int NUM_CH  = 7;

  // Lanes 0..2 are buttons (start, A, B), lanes 3..6 are X[1:0], Y[1:0].
  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] out_vec;

  assign raw_vec = {Y_raw, X_raw, pB_raw, pA_raw, start_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (i < NUM_BTN) begin : g_btn
      bic_chan #(
        .N   (BTN_DEBOUNCE),
        .INV (BTN_ACTIVE_LOW != 0),
        .EDGE(1'b1)
      ) u_chan (
        .clk(clk),
        .rst(rst),
        .raw(raw_vec[i]),
        .out(out_vec[i])
      );
    end else begin : g_sw
      bic_chan #(
        .N   (SW_DEBOUNCE),
        .INV (1'b0),
        .EDGE(1'b0)
      ) u_chan (
        .clk(clk),
        .rst(rst),
        .raw(raw_vec[i]),
        .out(out_vec[i])
      );
    end
  end

  assign start = out_vec[0];
  assign pAb   = out_vec[1];
  assign pBb   = out_vec[2];
  assign X     = out_vec[4:3];
  assign Y     = out_vec[6:5];
endmodule

// File: tb/tb_battleship_input_cond.sv
module tb_battleship_input_cond;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: active-high buttons, N=4
  logic       rst, start_raw, pA_raw, pB_raw;
  logic [1:0] X_raw, Y_raw;
  logic       start, pAb, pBb;
  logic [1:0] X, Y;

  // DUT1: active-low buttons, N=4
  logic       rst1, start_raw1, pA_raw1, pB_raw1;
  logic [1:0] X_raw1, Y_raw1;
  logic       start1, pAb1, pBb1;
  logic [1:0] X1, Y1;

  battleship_input_cond #(.BTN_DEBOUNCE(4), .SW_DEBOUNCE(4), .BTN_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .start_raw(start_raw), .pA_raw(pA_raw), .pB_raw(pB_raw),
    .X_raw(X_raw), .Y_raw(Y_raw), .start(start), .pAb(pAb), .pBb(pBb), .X(X), .Y(Y));

  battleship_input_cond #(.BTN_DEBOUNCE(4), .SW_DEBOUNCE(4), .BTN_ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst1), .start_raw(start_raw1), .pA_raw(pA_raw1), .pB_raw(pB_raw1),
    .X_raw(X_raw1), .Y_raw(Y_raw1), .start(start1), .pAb(pAb1), .pBb(pBb1), .X(X1), .Y(Y1));

  typedef struct {
    logic       rst, st, pa, pb;
    logic [1:0] x, y;
    logic       est, epa, epb;
    logic [1:0] ex, ey;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, st, pa, pb, input logic [1:0] x, y,
                     input logic est, epa, epb, input logic [1:0] ex, ey, input int n);
    vec_t v;
    v.rst = r; v.st = st; v.pa = pa; v.pb = pb; v.x = x; v.y = y;
    v.est = est; v.epa = epa; v.epb = epb; v.ex = ex; v.ey = ey;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start_raw = 0; pA_raw = 0; pB_raw = 0; X_raw = 0; Y_raw = 0;
    rst1 = 1'b1; start_raw1 = 1; pA_raw1 = 1; pB_raw1 = 1; X_raw1 = 0; Y_raw1 = 0;

    // fields: rst st pa pb x y | est epa epb ex ey | repeat
    // reset then idle
    add(1, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 2);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 20);
    // clean A press held 30 cycles: pulse after 6th edge only, release silent
    add(0, 0,1,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 5);
    add(0, 0,1,0, 2'd0,2'd0, 0,1,0, 2'd0,2'd0, 1);
    add(0, 0,1,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 24);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 10);
    // B bounce 1,0,1,1,0 then steady: pulse 6 edges after the last rise
    add(0, 0,0,1, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 1);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 1);
    add(0, 0,0,1, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 2);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 1);
    add(0, 0,0,1, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 5);
    add(0, 0,0,1, 2'd0,2'd0, 0,0,1, 2'd0,2'd0, 1);
    add(0, 0,0,1, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 4);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 10);
    // start glitch of 3 cycles is rejected
    add(0, 1,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 3);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 10);
    // a real start press afterwards still needs the full count
    add(0, 1,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 5);
    add(0, 1,0,0, 2'd0,2'd0, 1,0,0, 2'd0,2'd0, 1);
    add(0, 1,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 3);
    add(0, 0,0,0, 2'd0,2'd0, 0,0,0, 2'd0,2'd0, 10);
    // switches plus simultaneous A/B
    add(0, 0,1,1, 2'd2,2'd3, 0,0,0, 2'd0,2'd0, 5);
    add(0, 0,1,1, 2'd2,2'd3, 0,1,1, 2'd2,2'd3, 1);
    add(0, 0,1,1, 2'd2,2'd3, 0,0,0, 2'd2,2'd3, 4);
    add(0, 0,0,0, 2'd2,2'd3, 0,0,0, 2'd2,2'd3, 10);
    // both X bits flip together, Y clears
    add(0, 0,0,0, 2'd1,2'd0, 0,0,0, 2'd2,2'd3, 5);
    add(0, 0,0,0, 2'd1,2'd0, 0,0,0, 2'd1,2'd0, 5);
    // reset clears held switch level, which then re-qualifies
    add(1, 0,0,0, 2'd1,2'd0, 0,0,0, 2'd0,2'd0, 1);
    add(0, 0,0,0, 2'd1,2'd0, 0,0,0, 2'd0,2'd0, 5);
    add(0, 0,0,0, 2'd1,2'd0, 0,0,0, 2'd1,2'd0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; start_raw = tbl[i].st; pA_raw = tbl[i].pa; pB_raw = tbl[i].pb;
      X_raw = tbl[i].x; Y_raw = tbl[i].y;
      step();
      chk($sformatf("vec%0d", i), {start, pAb, pBb, X, Y},
          {tbl[i].est, tbl[i].epa, tbl[i].epb, tbl[i].ex, tbl[i].ey});
    end

    // reset at cnt=2: no pulse, count restarts from zero afterwards
    pA_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rstmid_pre%0d", k), {6'd0, pAb}, 7'd0);
    end
    rst = 1'b1;
    step();
    chk("rstmid_rst", {start, pAb, pBb, X, Y}, 7'd0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("rstmid_post%0d", k), {6'd0, pAb}, {6'd0, (k == 6)});
    end
    pA_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("rstmid_rel%0d", k), {4'd0, start, pAb, pBb}, 7'd0);
    end

    // active-low: released (1) through reset gives no spurious pulse
    for (int k = 1; k <= 2; k++) begin
      step();
      chk($sformatf("al_rst%0d", k), {start1, pAb1, pBb1, X1, Y1}, 7'd0);
    end
    rst1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("al_idle%0d", k), {start1, pAb1, pBb1, X1, Y1}, 7'd0);
    end
    pA_raw1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("al_press%0d", k), {start1, pAb1, pBb1, X1, Y1},
          {1'b0, (k == 6), 5'd0});
    end
    pA_raw1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("al_rel%0d", k), {start1, pAb1, pBb1, X1, Y1}, 7'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
